// File: rtl/moore_seq_detector.sv
// Moore serial sequence detector with optional overlapping matches.
// Next-state table is derived from the pattern when the design is elaborated.
module moore_seq_detector #(
   parameter int                     PATTERN_LEN = 3,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b101,
   parameter bit                     OVERLAP     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic x,
   output logic z
);

   localparam int SW = $clog2(PATTERN_LEN + 1);
   localparam int NS = 1 << SW;

   localparam logic [SW-1:0] S0      = '0;
   localparam logic [SW-1:0] S_MATCH = SW'(PATTERN_LEN);

   if (PATTERN_LEN < 2 || PATTERN_LEN > 8) begin : g_bad_len
      $error("moore_seq_detector: PATTERN_LEN must be 2..8");
   end

   // Pattern bit i in arrival order (i = 0 is the first bit received).
   function automatic logic pbit(input int i);
      logic [PATTERN_LEN-1:0] v;
      v = PATTERN >> (PATTERN_LEN - 1 - i);
      return v[0];
   endfunction

   // Bit p of the received string: matched prefix followed by b.
   function automatic logic sbit(input int p, input int base, input logic b);
      return (p < base) ? pbit(p) : b;
   endfunction

   function automatic logic [SW-1:0] kmp_next(input int k, input logic b);
      int   base;
      int   len;
      int   best;
      logic ok;
      best = 0;
      if (k > PATTERN_LEN) return S0;
      base = (k == PATTERN_LEN && !OVERLAP) ? 0 : k;
      if (base < PATTERN_LEN && b == pbit(base)) return SW'(base + 1);
      len = base + 1;
      for (int j = 1; j < len; j++) begin
         ok = 1'b1;
         for (int t = 0; t < j; t++) begin
            if (sbit(len - j + t, base, b) != pbit(t)) ok = 1'b0;
         end
         if (ok && j <= PATTERN_LEN) best = j;
      end
      return SW'(best);
   endfunction

   logic [SW-1:0] nxt_tbl [NS][2];

   for (genvar k = 0; k < NS; k++) begin : g_state
      for (genvar b = 0; b < 2; b++) begin : g_bit
         assign nxt_tbl[k][b] = kmp_next(k, 1'(b));
      end
   end

   logic [SW-1:0] current_state;
   logic [SW-1:0] next_state;

   always_comb begin
      next_state = nxt_tbl[current_state][x];
   end

   // z is registered alongside the state so it always equals (state == match).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         current_state <= S0;
         z             <= 1'b0;
      end else begin
         current_state <= next_state;
         z             <= (next_state == S_MATCH);
      end
   end

   a_z_decode: assert property (
      @(posedge clk) disable iff (!rst) z == (current_state == S_MATCH)
   );

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: overlap and non-overlap instances against
// a suffix-matching reference model plus literal state sequences.
module tb_moore_seq_detector;

   logic clk;
   logic rst;
   logic x;
   logic z_ov;
   logic z_no;

   int n_chk  = 0;
   int n_fail = 0;

   moore_seq_detector #(
      .PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1)
   ) dut_ov (
      .clk(clk), .rst(rst), .x(x), .z(z_ov)
   );

   moore_seq_detector #(
      .PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0)
   ) dut_no (
      .clk(clk), .rst(rst), .x(x), .z(z_no)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the state is the longest suffix of the received bits that
   // is a prefix of 101; a full-length suffix means a match.
   bit [2:0] PAT = 3'b101;

   function automatic int suffix_len(input bit q[$]);
      bit ok;
      for (int j = 3; j > 0; j--) begin
         if (j <= q.size()) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++)
               if (q[q.size() - j + t] != PAT[2 - t]) ok = 1'b0;
            if (ok) return j;
         end
      end
      return 0;
   endfunction

   bit h_ov[$];
   bit h_no[$];
   bit m_no;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_ov.delete();
         h_no.delete();
         m_no = 1'b0;
      end else begin
         h_ov.push_back(x);
         if (h_ov.size() > 3) void'(h_ov.pop_front());
         if (m_no) begin
            h_no.delete();
            m_no = 1'b0;
         end
         h_no.push_back(x);
         if (h_no.size() > 3) void'(h_no.pop_front());
         if (suffix_len(h_no) == 3) m_no = 1'b1;
      end
   end

   always @(negedge clk) begin
      int eo;
      int en;
      eo = suffix_len(h_ov);
      en = suffix_len(h_no);
      chk("model_state_ov", int'(dut_ov.current_state), eo);
      chk("model_z_ov", int'(z_ov), (eo == 3) ? 1 : 0);
      chk("model_state_no", int'(dut_no.current_state), en);
      chk("model_z_no", int'(z_no), (en == 3) ? 1 : 0);
   end

   task automatic step(input logic b);
      @(negedge clk);
      #2 x = b;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         x = ~x;
         #1;
         chk("rst_hold_state", int'(dut_ov.current_state), 0);
         chk("rst_hold_z", int'(z_ov), 0);
      end
      #1 rst = 1'b1;
   endtask

   int seq[$];
   int eo[$];
   int en[$];

   task automatic run_lit(input string name);
      for (int i = 0; i < seq.size(); i++) begin
         step(seq[i][0]);
         chk($sformatf("%s_ov_%0d", name, i),
             int'(dut_ov.current_state), eo[i]);
         chk($sformatf("%s_zov_%0d", name, i),
             int'(z_ov), (eo[i] == 3) ? 1 : 0);
         chk($sformatf("%s_no_%0d", name, i),
             int'(dut_no.current_state), en[i]);
      end
   endtask

   initial begin
      rst = 1'b0;
      x   = 1'b0;
      #1;
      chk("por_state", int'(dut_ov.current_state), 0);
      chk("por_z", int'(z_ov), 0);

      do_reset();
      seq = '{0, 0, 0};          eo = '{0, 0, 0};          en = '{0, 0, 0};
      run_lit("idle");

      do_reset();
      seq = '{0, 0, 1, 0, 1, 0}; eo = '{0, 0, 1, 2, 3, 2}; en = '{0, 0, 1, 2, 3, 0};
      run_lit("basic");

      do_reset();
      seq = '{1, 0, 1, 0, 1};    eo = '{1, 2, 3, 2, 3};    en = '{1, 2, 3, 0, 1};
      run_lit("overlap");

      do_reset();
      seq = '{1, 1, 0};          eo = '{1, 1, 2};          en = '{1, 1, 2};
      run_lit("nm110");
      do_reset();
      seq = '{0, 1, 1};          eo = '{0, 1, 1};          en = '{0, 1, 1};
      run_lit("nm011");
      do_reset();
      seq = '{1, 0, 0};          eo = '{1, 2, 0};          en = '{1, 2, 0};
      run_lit("nm100");

      do_reset();
      seq = '{1, 0};             eo = '{1, 2};             en = '{1, 2};
      run_lit("pre_async");
      #2 rst = 1'b0;
      #1;
      chk("async_state_ov", int'(dut_ov.current_state), 0);
      chk("async_z_ov", int'(z_ov), 0);
      chk("async_state_no", int'(dut_no.current_state), 0);
      #1 rst = 1'b1;
      seq = '{1, 0, 1};          eo = '{1, 2, 3};          en = '{1, 2, 3};
      run_lit("post_async");

      do_reset();
      seq = '{1, 0, 1, 1, 0, 1}; eo = '{1, 2, 3, 1, 2, 3}; en = '{1, 2, 3, 1, 2, 3};
      run_lit("b2b");

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            #2 rst = 1'b0;
            #2 rst = 1'b1;
         end
         step(1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
